// File: rtl/uo_mon_pkg.sv
// Shared types and constants for the uo_out UART observation stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uo_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// Latency: a pushed word is visible on rd_dat the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full and empty cases.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign rd_dat  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/uo_uart_monitor.sv
// Captures changes on the project's uo_out bus and replays them as UART 8N1 frames.
// Latency: change sampled at edge N, popped at N+1, start bit drives tx after N+1.
// Backpressure: none upstream; captures arriving while the FIFO is full are dropped and flagged.
module uo_uart_monitor
  import uo_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [7:0]                  data_in,
  input  logic                        force_send,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int            TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int            IW       = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  tx_state_t                 state_q;
  tx_state_t                 state_d;
  logic [TW-1:0]             timer_q;
  logic [TW-1:0]             timer_d;
  logic [IW-1:0]             idx_q;
  logic [IW-1:0]             idx_d;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic                      tx_bit;
  logic                      bit_end;

  logic [7:0]                prev_q;
  logic                      cap_push;
  logic                      overflow_q;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [7:0]                fifo_rd_dat;

  // A capture is a changed byte, or any byte when software asks for a resend.
  assign cap_push = en && ((data_in != prev_q) || force_send);

  // Last sampled value of the bus; frozen while capture is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 8'h00;
    end else if (en) begin
      prev_q <= data_in;
    end
  end

  // Sticky drop flag: a capture was lost because no slot was free.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (cap_push && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cap_push),
    .wr_dat (data_in),
    .pop    (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign bit_end = (timer_q == BIT_LAST);

  // Transmitter state, bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and line level; the timer only advances inside a frame.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_bit   = 1'b1;
    case (state_q)
      IDLE: begin
        tx_bit = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_dat;
          timer_d  = '0;
          state_d  = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        tx_bit = shift_q[0];
        if (bit_end) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        tx_bit = 1'b1;
        if (bit_end) begin
          timer_d = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_dat;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx       = tx_bit;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: doc/uo_uart_monitor.md
Name: uo_uart_monitor

Overview:
- Downstream observation stage for the tt_um_usman user project.
- Watches the project's 8-bit dedicated output bus (uo_out) and queues each new value in a small FIFO.
- Serialises queued bytes as UART 8N1 frames on a single pin, so bench and board readout see the output stream without parallel probing.
- Instantiated beside the user project in the tb top and in board-level debug builds.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range >= 2.
- FIFO_DEPTH, 4, byte entries in the capture FIFO; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; the transmitter keeps draining when low.
- data_in  input  8  observed bus, connected to the project's uo_out.
- force_send  input  1  one-cycle pulse; queues data_in even when it is unchanged.
- tx  output  1  UART serial out; idles high.
- tx_busy  output  1  high when FSM not IDLE or FIFO non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a capture is dropped.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - tx=1, tx_busy=0, fifo_level=0, overflow=0.
  - FSM=IDLE; internal prev register = 8'h00.
  - Reset mid-frame aborts the frame: tx=1 after that edge, FIFO contents discarded.
- Capture:
  - At each edge with en=1: push = (data_in != prev) | force_send.
  - prev <= data_in at that edge. With en=0, prev holds and nothing is pushed.
  - First non-zero value after reset is therefore captured.
- FIFO:
  - Synchronous, first-word-fall-through read.
  - Push when full and no pop on the same edge: byte dropped, overflow<=1.
  - overflow clears only on rst.
  - Push and pop on the same edge when full: push accepted, level unchanged, no overflow.
- TX FSM states: IDLE, START, DATA, STOP. Each non-IDLE bit lasts exactly CLKS_PER_BIT cycles.
  - IDLE: tx=1. If FIFO non-empty: pop into shift register, go to START.
  - START: tx=0. After CLKS_PER_BIT cycles go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Shift after each bit; after bit 7 go to STOP.
  - STOP: tx=1. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Timing:
  - Latency: change sampled at edge N -> FIFO non-empty after N -> pop at edge N+1 -> tx falls after edge N+1.
  - Frame length: exactly 10*CLKS_PER_BIT cycles.
- Counters:
  - Bit-timer width $clog2(CLKS_PER_BIT).
  - Counters wrap only under FSM control, never free-running.

Decomposition:
- Package uo_mon_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - UART_DATA_BITS=8, UART_FRAME_BITS=10.
- Sub-module sync_fifo:
  - Parameterised WIDTH=8, DEPTH.
  - Ports push/pop/full/empty/level.
  - Pointers one bit wider than the address.
- FSM, bit timer and change detect stay in uo_uart_monitor.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset hold 3 cycles -> tx=1, tx_busy=0, fifo_level=0, overflow=0; data_in=00 for 20 cycles gives no frame.
- data_in 00->A5 at edge N:
  - tx=0 for cycles N+2..N+5.
  - Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high.
  - tx_busy falls after 40 frame cycles.
- Hold A5 for 100 cycles -> no second frame; one force_send pulse -> exactly one more A5 frame.
- data_in 01,02,03,04,05,06 on consecutive edges:
  - Frames 01..05 sent back-to-back with no idle gap; 06 dropped.
  - overflow=1, and it stays 1 after the FIFO drains.
- Reset asserted during DATA bit 3 of an A5 frame:
  - tx=1 and fifo_level=0 on the next cycle.
  - After release, data_in=3C produces one correct 3C frame.
- en=0 while data_in toggles 11/22 -> no frames; en=1 with data_in=33 (prev=00) -> one 33 frame.
